// File: rtl/iter_shift_unit_if.sv
// Handshake/bus bundle between the control unit and the iterative shift unit.
// CarryOut exists only when SHIFT_CARRY_EN is defined.
interface iter_shift_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 5
);
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    logic               start;
    logic               imm_sel;
    logic [DATA_W-1:0]  OperandA;
    logic [IMM_W-1:0]   Immediate;
    logic [1:0]         Mode;
    logic [SHAMT_W-1:0] Amount;
    logic               busy;
    logic               done;
    logic [DATA_W-1:0]  Result;
`ifdef SHIFT_CARRY_EN
    logic               CarryOut;

    modport master (
        output start, imm_sel, OperandA, Immediate, Mode, Amount,
        input  busy, done, Result, CarryOut
    );

    modport slave (
        input  start, imm_sel, OperandA, Immediate, Mode, Amount,
        output busy, done, Result, CarryOut
    );
`else
    modport master (
        output start, imm_sel, OperandA, Immediate, Mode, Amount,
        input  busy, done, Result
    );

    modport slave (
        input  start, imm_sel, OperandA, Immediate, Mode, Amount,
        output busy, done, Result
    );
`endif
endinterface

// File: rtl/iter_shift_unit.sv
// Iterative shift unit: shifts a register or sign-extended immediate one bit per clock.
// Optional feature: define SHIFT_CARRY_EN to add the CarryOut register/port.
module iter_shift_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 5
) (
    input logic              clk,
    input logic              rst_n,
    iter_shift_unit_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t             state;
    logic               busy_q;
    logic               done_q;
    logic [DATA_W-1:0]  result_q;
    logic [SHAMT_W-1:0] count_q;
    logic [1:0]         mode_q;

    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  shifted;
    logic               accept;
    logic               shift_en;

    assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign shift_en = (state == S_SHIFT) && (count_q != '0);

    // Operand selection: immediate is sign-extended to the datapath width.
    always_comb begin
        operand = bus.OperandA;
        if (bus.imm_sel) begin
            operand = DATA_W'($signed(bus.Immediate));
        end
    end

    // One-bit step of the latched mode.
    always_comb begin
        shifted = result_q;
        unique case (mode_q)
            MODE_SLL: shifted = {result_q[DATA_W-2:0], 1'b0};
            MODE_SRL: shifted = {1'b0, result_q[DATA_W-1:1]};
            MODE_SRA: shifted = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
            MODE_ROL: shifted = {result_q[DATA_W-2:0], result_q[DATA_W-1]};
            default:  shifted = result_q;
        endcase
    end

    // Control FSM with registered busy/done and the shift register itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            mode_q   <= MODE_SLL;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state    <= S_SHIFT;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        result_q <= operand;
                        mode_q   <= bus.Mode;
                        count_q  <= bus.Amount;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        result_q <= shifted;
                        count_q  <= count_q - SHAMT_W'(1);
                    end else begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;

`ifdef SHIFT_CARRY_EN
    logic carry_q;
    logic carry_bit;

    // Left-going modes lose the MSB, right-going modes lose the LSB.
    always_comb begin
        carry_bit = result_q[0];
        if ((mode_q == MODE_SLL) || (mode_q == MODE_ROL)) begin
            carry_bit = result_q[DATA_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (accept) begin
            carry_q <= 1'b0;
        end else if (shift_en) begin
            carry_q <= carry_bit;
        end
    end

    assign bus.CarryOut = carry_q;
`endif

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit (carry checks only when SHIFT_CARRY_EN is defined).
module tb_iter_shift_unit;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IMM_W  = 5;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cycle;
    int   t0;
    int   lat;

    iter_shift_unit_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

    iter_shift_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Present one request for a single edge, then scramble the inputs.
    task automatic launch(input logic isel, input logic [15:0] a, input logic [4:0] imm,
                          input logic [1:0] m, input logic [3:0] amt);
        bus.imm_sel   = isel;
        bus.OperandA  = a;
        bus.Immediate = imm;
        bus.Mode      = m;
        bus.Amount    = amt;
        bus.start     = 1'b1;
        t0 = cycle;
        tick();
        bus.start     = 1'b0;
        bus.OperandA  = 16'hDEAD;
        bus.Immediate = 5'h0A;
        bus.Mode      = ~m;
        bus.Amount    = ~amt;
    endtask

    task automatic wait_done(input int limit);
        while (bus.done !== 1'b1 && (cycle - t0) < limit) tick();
        lat = cycle - t0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        t0     = 0;
        lat    = 0;
        rst_n  = 1'b0;
        bus.start = 1'b0; bus.imm_sel = 1'b0; bus.OperandA = '0;
        bus.Immediate = '0; bus.Mode = SLL; bus.Amount = '0;

        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", 32'(bus.Result), 32'h0);
`ifdef SHIFT_CARRY_EN
        check("reset_carry", 32'(bus.CarryOut), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // T1
        launch(1'b0, 16'h00F3, 5'h00, SLL, 4'd4);
        check("t1_busy", 32'(bus.busy), 32'd1);
        wait_done(40);
        check("t1_latency", 32'(lat), 32'd6);
        check("t1_result", 32'(bus.Result), 32'h0F30);
        check("t1_busy_at_done", 32'(bus.busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(bus.done), 32'd0);
        check("t1_result_held", 32'(bus.Result), 32'h0F30);

        // T2
        launch(1'b1, 16'h0000, 5'b10110, SLL, 4'd1);
        wait_done(40);
        check("t2_latency", 32'(lat), 32'd3);
        check("t2_result", 32'(bus.Result), 32'hFFEC);
        tick();

        // T3
        launch(1'b0, 16'h8000, 5'h00, SRA, 4'd15);
        wait_done(40);
        check("t3_sra_latency", 32'(lat), 32'd17);
        check("t3_sra_result", 32'(bus.Result), 32'hFFFF);
        tick();
        launch(1'b0, 16'h8000, 5'h00, SRL, 4'd15);
        wait_done(40);
        check("t3_srl_result", 32'(bus.Result), 32'h0001);
`ifdef SHIFT_CARRY_EN
        check("t3_srl_carry", 32'(bus.CarryOut), 32'd0);
`endif
        tick();

        // T4
        launch(1'b0, 16'h8001, 5'h00, ROL, 4'd1);
        wait_done(40);
        check("t4_result", 32'(bus.Result), 32'h0003);
`ifdef SHIFT_CARRY_EN
        check("t4_carry", 32'(bus.CarryOut), 32'd1);
`endif
        tick();

        // Amount=0: operand passes through, done two cycles after start
        launch(1'b0, 16'h1234, 5'h00, SRL, 4'd0);
        wait_done(40);
        check("amt0_latency", 32'(lat), 32'd2);
        check("amt0_result", 32'(bus.Result), 32'h1234);
`ifdef SHIFT_CARRY_EN
        check("amt0_carry", 32'(bus.CarryOut), 32'd0);
`endif
        tick();

        // T5: start while busy is ignored
        launch(1'b0, 16'h0001, 5'h00, SLL, 4'd8);
        tick();
        bus.start = 1'b1; bus.imm_sel = 1'b1; bus.Immediate = 5'h1F;
        bus.OperandA = 16'hFFFF; bus.Mode = ROL; bus.Amount = 4'd1;
        tick();
        bus.start = 1'b0;
        wait_done(40);
        check("t5_latency", 32'(lat), 32'd10);
        check("t5_result", 32'(bus.Result), 32'h0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_single_done", 32'(bus.done), 32'd0);
        end
        check("t5_idle", 32'(bus.busy), 32'd0);
        check("t5_result_held", 32'(bus.Result), 32'h0100);

        // T6: asynchronous reset mid-shift
        launch(1'b0, 16'h00FF, 5'h00, SLL, 4'd8);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_done", 32'(bus.done), 32'd0);
        check("t6_result", 32'(bus.Result), 32'h0);
        tick();
        check("t6_no_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        launch(1'b0, 16'h000F, 5'h00, SRL, 4'd2);
        wait_done(40);
        check("t6_after_latency", 32'(lat), 32'd4);
        check("t6_after_result", 32'(bus.Result), 32'h0003);
        tick();

        // T7: start held high across done accepts the next op back-to-back
        bus.imm_sel = 1'b0; bus.OperandA = 16'h0003; bus.Mode = SLL; bus.Amount = 4'd2;
        bus.start = 1'b1;
        t0 = cycle;
        tick();
        bus.OperandA = 16'h00F0; bus.Mode = SRL; bus.Amount = 4'd4;
        wait_done(40);
        check("t7_first_latency", 32'(lat), 32'd4);
        check("t7_first_result", 32'(bus.Result), 32'h000C);
        t0 = cycle;
        tick();
        bus.start = 1'b0;
        check("t7_done_drop", 32'(bus.done), 32'd0);
        check("t7_busy_rise", 32'(bus.busy), 32'd1);
        wait_done(40);
        check("t7_second_latency", 32'(lat), 32'd6);
        check("t7_second_result", 32'(bus.Result), 32'h000F);
        tick();
        check("t7_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
